// File: rtl/seg_display_if.sv
// Bundle of the FIFO read-side word, display controls and the 7-segment outputs
// exchanged between a producer (master) and seg_display_ctrl (slave).
interface seg_display_if;
    logic [15:0] data_in;
    logic        data_valid;
    logic        src_sel;
    logic [2:0]  prog;
    logic        busy;
    logic        overrun;
    logic [7:0]  an;
    logic [7:0]  dec_ddp;

    modport master (
        output data_in, data_valid, src_sel, prog,
        input  busy, overrun, an, dec_ddp
    );

    modport slave (
        input  data_in, data_valid, src_sel, prog,
        output busy, overrun, an, dec_ddp
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// Binary-to-BCD converter (sequential double dabble) feeding an 8-digit common-anode scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros of value digits 4..1.
//
//  state   | meaning
//  S_IDLE  | waiting for a word (direct or pending)
//  S_SHIFT | 16 add-3/shift iterations on the 36-bit shift register
//  S_DONE  | commit BCD digits and source tag to the display registers
module seg_display_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic         clk,
    input  logic         rst,
    seg_display_if.slave bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [35:0]       shreg, shreg_nxt, adj;
    logic [3:0]        iter, iter_nxt;
    logic              src_sh, src_sh_nxt;
    logic [15:0]       pend, pend_nxt;
    logic              pend_src, pend_src_nxt;
    logic              pend_vld, pend_vld_nxt;
    logic              overrun_q, overrun_nxt;
    logic [4:0][3:0]   digits, digits_nxt;
    logic              src_disp, src_disp_nxt;

    logic [CNT_W-1:0]  refresh_cnt;
    logic [2:0]        idx;
    logic [7:0]        an_q, seg_q, seg_sel;
    logic [4:0]        blank;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Add 3 to every BCD nibble >= 5 before the shift.
    always_comb begin
        adj = shreg;
        for (int k = 0; k < 5; k++) begin
            if (shreg[16+4*k +: 4] >= 4'd5)
                adj[16+4*k +: 4] = shreg[16+4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        iter_nxt     = iter;
        src_sh_nxt   = src_sh;
        pend_nxt     = pend;
        pend_src_nxt = pend_src;
        pend_vld_nxt = pend_vld;
        overrun_nxt  = overrun_q;
        digits_nxt   = digits;
        src_disp_nxt = src_disp;

        case (state)
            S_IDLE: begin
                if (pend_vld) begin
                    shreg_nxt  = {20'b0, pend};
                    src_sh_nxt = pend_src;
                    iter_nxt   = 4'd0;
                    state_nxt  = S_SHIFT;
                    if (bus.data_valid) begin
                        pend_nxt     = bus.data_in;
                        pend_src_nxt = bus.src_sel;
                    end else begin
                        pend_vld_nxt = 1'b0;
                    end
                end else if (bus.data_valid) begin
                    shreg_nxt  = {20'b0, bus.data_in};
                    src_sh_nxt = bus.src_sel;
                    iter_nxt   = 4'd0;
                    state_nxt  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_nxt = adj << 1;
                iter_nxt  = iter + 4'd1;
                if (iter == 4'd15)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                digits_nxt   = shreg[35:16];
                src_disp_nxt = src_sh;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Words arriving mid-conversion park in the 1-deep buffer; newest wins.
        if (state != S_IDLE && bus.data_valid) begin
            if (pend_vld)
                overrun_nxt = 1'b1;
            pend_nxt     = bus.data_in;
            pend_src_nxt = bus.src_sel;
            pend_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            iter      <= '0;
            src_sh    <= 1'b0;
            pend      <= '0;
            pend_src  <= 1'b0;
            pend_vld  <= 1'b0;
            overrun_q <= 1'b0;
            digits    <= '0;
            src_disp  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            iter      <= iter_nxt;
            src_sh    <= src_sh_nxt;
            pend      <= pend_nxt;
            pend_src  <= pend_src_nxt;
            pend_vld  <= pend_vld_nxt;
            overrun_q <= overrun_nxt;
            digits    <= digits_nxt;
            src_disp  <= src_disp_nxt;
        end
    end

    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        blank[4] = (digits[4] == 4'd0);
        blank[3] = blank[4] && (digits[3] == 4'd0);
        blank[2] = blank[3] && (digits[2] == 4'd0);
        blank[1] = blank[2] && (digits[1] == 4'd0);
`endif
    end

    always_comb begin
        seg_sel = 8'hFF;
        case (idx)
            3'd0: seg_sel = blank[0] ? 8'hFF : seg7(digits[0]);
            3'd1: seg_sel = blank[1] ? 8'hFF : seg7(digits[1]);
            3'd2: seg_sel = blank[2] ? 8'hFF : seg7(digits[2]);
            3'd3: seg_sel = blank[3] ? 8'hFF : seg7(digits[3]);
            3'd4: seg_sel = blank[4] ? 8'hFF : seg7(digits[4]);
            3'd5: seg_sel = 8'hFF;
            3'd6: seg_sel = src_disp ? 8'h87 : 8'h8E;
            3'd7: seg_sel = seg7({1'b0, bus.prog});
            default: seg_sel = 8'hFF;
        endcase
    end

    // Slot timer counts down from REFRESH_DIV-1; terminal count advances the digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= RELOAD;
            idx         <= 3'd0;
            an_q        <= 8'hFF;
            seg_q       <= 8'hFF;
        end else begin
            if (refresh_cnt == '0) begin
                refresh_cnt <= RELOAD;
                idx         <= idx + 3'd1;
            end else begin
                refresh_cnt <= refresh_cnt - CNT_W'(1);
            end
            an_q  <= ~(8'd1 << idx);
            seg_q <= seg_sel;
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.overrun = overrun_q;
    assign bus.an      = an_q;
    assign bus.dec_ddp = seg_q;

endmodule
